// File: rtl/pa_noc.sv
// pa_noc: packet layout shared by the mesh, the ingress buffers and their clients.
// A packet is {valid, payload[22:0], dest_x[3:0], dest_y[3:0]}.
package pa_noc;
    localparam int APB_PACKET_WIDTH = 32;
    localparam int PKT_VALID_BIT    = APB_PACKET_WIDTH - 1;
    localparam int COORD_W          = 4;
    localparam int DEST_X_LSB       = 4;
    localparam int DEST_Y_LSB       = 0;
    localparam logic [APB_PACKET_WIDTH-1:0] PKT_IDLE = '0;

    function automatic logic [COORD_W-1:0] pkt_dest_x(input logic [APB_PACKET_WIDTH-1:0] p);
        return p[DEST_X_LSB +: COORD_W];
    endfunction

    function automatic logic [COORD_W-1:0] pkt_dest_y(input logic [APB_PACKET_WIDTH-1:0] p);
        return p[DEST_Y_LSB +: COORD_W];
    endfunction
endpackage

// File: rtl/noc_buffered_if.sv
// noc_buffered_if: client-side packet bundle covering every node of the grid.
interface noc_buffered_if
    import pa_noc::*;
#(
    parameter int G  = 4,
    parameter int OW = 3
);
    logic [G-1:0][G-1:0][APB_PACKET_WIDTH-1:0] i_pkt;
    logic [G-1:0][G-1:0]                       i_pktValid;
    logic [G-1:0][G-1:0]                       o_pktReady;
    logic [G-1:0][G-1:0][APB_PACKET_WIDTH-1:0] o_pkt;
    logic [G-1:0][G-1:0]                       o_pktValid;
    logic [G-1:0][G-1:0][OW-1:0]               o_occupancy;

    modport master (output i_pkt, i_pktValid, input o_pktReady, o_pkt, o_pktValid, o_occupancy);
    modport slave  (input i_pkt, i_pktValid, output o_pktReady, o_pkt, o_pktValid, o_occupancy);
endinterface

// File: rtl/mesh.sv
// mesh: single-hop fabric; a valid packet reaches its destination router port one
// cycle after it is presented, the highest-indexed source winning on contention.
module mesh
    import pa_noc::*;
#(
    parameter int GRID_WIDTH = 4
) (
    input  logic i_clk,
    input  logic i_arst_n,
    input  logic [GRID_WIDTH-1:0][GRID_WIDTH-1:0][APB_PACKET_WIDTH-1:0] i_niToRouter,
    output logic [GRID_WIDTH-1:0][GRID_WIDTH-1:0][APB_PACKET_WIDTH-1:0] o_routerToNi
);
    localparam int G = GRID_WIDTH;

    logic [G-1:0][G-1:0][APB_PACKET_WIDTH-1:0] out_d, out_q;

    for (genvar x = 0; x < G; x++) begin : g_x
        for (genvar y = 0; y < G; y++) begin : g_y
            for (genvar s = 0; s < G * G; s++) begin : g_s
                logic [APB_PACKET_WIDTH-1:0] acc;
                logic                        hit;
                assign hit = i_niToRouter[s/G][s%G][PKT_VALID_BIT]
                          && pkt_dest_x(i_niToRouter[s/G][s%G]) == COORD_W'(x)
                          && pkt_dest_y(i_niToRouter[s/G][s%G]) == COORD_W'(y);
                if (s == 0) begin : g_first
                    assign acc = hit ? i_niToRouter[0][0] : PKT_IDLE;
                end else begin : g_next
                    assign acc = hit ? i_niToRouter[s/G][s%G] : g_s[s-1].acc;
                end
            end
            assign out_d[x][y] = g_s[G*G-1].acc;
        end
    end

    always_ff @(posedge i_clk or negedge i_arst_n)
        if (!i_arst_n) out_q <= '0;
        else           out_q <= out_d;

    assign o_routerToNi = out_q;
endmodule

// File: rtl/noc_ni_ingress.sv
// noc_ni_ingress: per-node ingress FIFO with registered ready and a gap counter
// that rate-limits injection toward the router.
module noc_ni_ingress
    import pa_noc::*;
#(
    parameter int FIFO_DEPTH = 4,
    parameter int INJECT_GAP = 0,
    localparam int AW = $clog2(FIFO_DEPTH),
    localparam int OW = $clog2(FIFO_DEPTH + 1),
    localparam int GW = INJECT_GAP > 0 ? $clog2(INJECT_GAP + 1) : 1
) (
    input  logic                        i_clk,
    input  logic                        i_arst_n,
    input  logic [APB_PACKET_WIDTH-1:0] i_pkt,
    input  logic                        i_pktValid,
    output logic                        o_pktReady,
    output logic [APB_PACKET_WIDTH-1:0] o_niToRouter,
    output logic [OW-1:0]               o_occupancy
);
    logic [APB_PACKET_WIDTH-1:0] mem_q [FIFO_DEPTH];
    logic [AW-1:0]               wr_d, wr_q, rd_d, rd_q;
    logic [OW-1:0]               occ_d, occ_q;
    logic [GW-1:0]               gap_d, gap_q;
    logic [APB_PACKET_WIDTH-1:0] inj_d, inj_q;
    logic                        rdy_d, rdy_q, push, pop;

    // Ready is computed from the post-update occupancy so a same-cycle pop frees the slot.
    always_comb begin
        push  = i_pktValid && rdy_q;
        pop   = (occ_q != '0) && (gap_q == '0);
        wr_d  = wr_q + AW'(push);
        rd_d  = rd_q + AW'(pop);
        occ_d = occ_q + OW'(push) - OW'(pop);
        rdy_d = occ_d != OW'(FIFO_DEPTH);
        gap_d = pop ? GW'(INJECT_GAP) : (gap_q != '0 ? gap_q - GW'(1) : gap_q);
        inj_d = pop ? mem_q[rd_q] : PKT_IDLE;
    end

    always_ff @(posedge i_clk)
        if (push) mem_q[wr_q] <= i_pkt;

    always_ff @(posedge i_clk or negedge i_arst_n)
        if (!i_arst_n) begin
            wr_q  <= '0;
            rd_q  <= '0;
            occ_q <= '0;
            rdy_q <= 1'b0;
            gap_q <= '0;
            inj_q <= PKT_IDLE;
        end else begin
            wr_q  <= wr_d;
            rd_q  <= rd_d;
            occ_q <= occ_d;
            rdy_q <= rdy_d;
            gap_q <= gap_d;
            inj_q <= inj_d;
        end

    assign o_pktReady   = rdy_q;
    assign o_niToRouter = inj_q;
    assign o_occupancy  = occ_q;
endmodule

// File: rtl/noc_buffered.sv
// noc_buffered: mesh with a buffered, rate-limited ingress per node and a
// registered egress stage toward the clients.
module noc_buffered #(
    parameter int GRID_WIDTH = 4,
    parameter int FIFO_DEPTH = 4,
    parameter int INJECT_GAP = 0
) (
    input  logic           i_clk,
    input  logic           i_arst_n,
    noc_buffered_if.slave  bus
);
    localparam int APB_PACKET_WIDTH = pa_noc::APB_PACKET_WIDTH;
    localparam int G                = GRID_WIDTH;

    if (GRID_WIDTH < 2) begin : g_bad_grid
        $error("noc_buffered: GRID_WIDTH must be at least 2");
    end
    if (FIFO_DEPTH < 2 || (FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0) begin : g_bad_depth
        $error("noc_buffered: FIFO_DEPTH must be a power of two of at least 2");
    end

    logic [G-1:0][G-1:0][APB_PACKET_WIDTH-1:0] ni_to_router, router_to_ni, pkt_d, pkt_q;
    logic [G-1:0][G-1:0]                       valid_d, valid_q;

    for (genvar x = 0; x < G; x++) begin : g_x
        for (genvar y = 0; y < G; y++) begin : g_y
            noc_ni_ingress #(
                .FIFO_DEPTH (FIFO_DEPTH),
                .INJECT_GAP (INJECT_GAP)
            ) u_ingress (
                .i_clk        (i_clk),
                .i_arst_n     (i_arst_n),
                .i_pkt        (bus.i_pkt[x][y]),
                .i_pktValid   (bus.i_pktValid[x][y]),
                .o_pktReady   (bus.o_pktReady[x][y]),
                .o_niToRouter (ni_to_router[x][y]),
                .o_occupancy  (bus.o_occupancy[x][y])
            );
            assign valid_d[x][y] = router_to_ni[x][y][pa_noc::PKT_VALID_BIT];
        end
    end

    mesh #(
        .GRID_WIDTH (GRID_WIDTH)
    ) u_mesh (
        .i_clk        (i_clk),
        .i_arst_n     (i_arst_n),
        .i_niToRouter (ni_to_router),
        .o_routerToNi (router_to_ni)
    );

    always_comb pkt_d = router_to_ni;

    always_ff @(posedge i_clk or negedge i_arst_n)
        if (!i_arst_n) begin
            pkt_q   <= '0;
            valid_q <= '0;
        end else begin
            pkt_q   <= pkt_d;
            valid_q <= valid_d;
        end

    assign bus.o_pkt      = pkt_q;
    assign bus.o_pktValid = valid_q;
endmodule

// File: doc/noc_buffered.md
# noc_buffered

Parametrised top level of the network-on-chip. Instantiates `mesh` and places a per-node ingress network-interface buffer in front of every router, with a valid/ready handshake on the client side and programmable injection-rate limiting toward the mesh. Router-to-client traffic is registered and qualified with a per-node valid strobe. It supersedes `noc` as the integration point for client blocks.

## Interface

Parameters:
- `GRID_WIDTH`, 4: mesh is `GRID_WIDTH` x `GRID_WIDTH`; must be ≥2.
- `FIFO_DEPTH`, 4: ingress FIFO entries per node; power of two, ≥2.
- `INJECT_GAP`, 0: minimum idle cycles between consecutive injections from one node; 0 allows back-to-back injection.
- `APB_PACKET_WIDTH` (localparam), `pa_noc::APB_PACKET_WIDTH`: packet width.

Ports (`G` = `GRID_WIDTH`, `W` = `APB_PACKET_WIDTH`, `OW` = `$clog2(FIFO_DEPTH+1)`):
- `i_clk`  in  1  the single clock.
- `i_arst_n`  in  1  asynchronous, active-low reset.
- `i_pkt`  in  [G][G][W]  client packet per node.
- `i_pktValid`  in  [G][G]  client packet valid per node.
- `o_pktReady`  out  [G][G]  ingress can accept per node.
- `o_pkt`  out  [G][G][W]  registered packet delivered by the router.
- `o_pktValid`  out  [G][G]  delivery strobe per node.
- `o_occupancy`  out  [G][G][OW]  ingress FIFO fill level.

## Operation

- Packet valid is bit `W-1`, defined as `pa_noc::PKT_VALID_BIT`. The all-zero packet is the idle encoding on mesh ports.
- Ingress handshake: a transfer occurs on a rising edge where `i_pktValid && o_pktReady`. The client holds `i_pkt` and `i_pktValid` stable until the transfer. Packets are never dropped.
- `o_pktReady` is registered and equals `!full` for the next cycle. It accounts for a push and a pop occurring in the same cycle.
- Injection: a node pops its FIFO head when the FIFO is non-empty and the gap counter is 0. The popped packet is registered onto that node's mesh input for exactly one cycle. In every other cycle the mesh input is driven all-zero.
- Gap counter: loads `INJECT_GAP` on each injection and decrements to 0, saturating at 0.
- Push and pop in the same cycle are permitted. Occupancy is unchanged and the pointers wrap modulo `FIFO_DEPTH`.
- Egress: `o_pkt <= o_routerToNi[node]` every cycle. `o_pktValid <=` the router output's valid bit.
- Nodes are fully independent. There is no cross-node arbitration in this block.

## Timing

- Reset values (asynchronous): FIFO pointers 0, occupancy 0, `o_pktReady` 0, gap counter 0, mesh inputs 0, `o_pkt` 0, `o_pktValid` 0.
- `o_pktReady` rises on the first rising edge after `i_arst_n` deasserts.
- Ingress latency, empty FIFO with gap 0: packet accepted at edge N is on the mesh input from edge N+1 to N+2.
- Egress latency: 1 cycle from the router output to `o_pkt`/`o_pktValid`.
- Full FIFO: `o_pktReady` is low in the cycle after occupancy reaches `FIFO_DEPTH`. It returns high in the cycle after the first pop.
- Empty FIFO: no injection occurs; the mesh input stays zero.
- Reset asserted mid-operation: all buffered packets are discarded immediately and outputs go to their reset values.
- Parameter violations (`GRID_WIDTH<2`, `FIFO_DEPTH` not a power of two or <2) raise an elaboration `$error`.

## Structure

- `pa_noc` holds `APB_PACKET_WIDTH`, `PKT_VALID_BIT`, and a `PKT_IDLE` constant (all zero).
- Sub-module `noc_ni_ingress`: one FIFO, the ready register, the gap counter and the injection register. It is instanced via a `G`x`G` generate loop alongside `mesh`.
- Egress registers live in the top level.

## Test plan

- Reset: hold `i_arst_n` low for 3 cycles with `i_pktValid`=1. Expect all outputs 0 and no transfer. `o_pktReady`=1 one edge after release.
- Single packet at node (0,0) to (3,3), `INJECT_GAP`=0: mesh input is non-zero for exactly 1 cycle, 1 cycle after acceptance. `o_pktValid[3][3]` pulses once with an identical `o_pkt`.
- Fill: `FIFO_DEPTH`=4, mesh inputs back-pressured by `INJECT_GAP`=7, 6 valid cycles. Expect `o_occupancy` to reach 4, `o_pktReady` low, and every packet delivered in order.
- `INJECT_GAP`=2, 3 packets queued: injections spaced exactly 3 cycles apart.
- Simultaneous push/pop at occupancy 1 across a pointer wrap: occupancy stays 1 and delivery order is preserved.
- Reset asserted with 3 packets queued: occupancy goes to 0 and no residual packet reaches the mesh after release.
